// File: rtl/cpu_pipe_control_if.sv
// ---------------------------------------------------------------------------
// cpu_pipe_control_if
// ID-stage instruction and branch inputs plus the stall/flush and registered
// ID/EX control outputs of the pipeline controller.
// master: the pipeline datapath (IF/ID register, EX stage) side.
// slave : the cpu_pipe_control block.
// ---------------------------------------------------------------------------
interface cpu_pipe_control_if #(
   parameter int INSTR_W = 32,
   parameter int REG_AW  = 4
);
   logic [INSTR_W-1:0] id_instr;
   logic               id_valid;
   logic               br_taken;
   logic               stall_if;
   logic               flush_id;
   logic               ex_valid;
   logic [7:0]         ex_alu_op;
   logic               ex_alu_imm_src;
   logic               ex_rf_write_en;
   logic               ex_datamem_write_en;
   logic               ex_datamem_read_en;
   logic               ex_rf_write_mem_src;
   logic               ex_pc_src;
   logic               ex_pc_jmp_src;
   logic [REG_AW-1:0]  ex_rd;
   logic               ex_uop;
   logic               ex_err;

   modport master (
      output id_instr, id_valid, br_taken,
      input  stall_if, flush_id, ex_valid, ex_alu_op, ex_alu_imm_src,
             ex_rf_write_en, ex_datamem_write_en, ex_datamem_read_en,
             ex_rf_write_mem_src, ex_pc_src, ex_pc_jmp_src, ex_rd, ex_uop,
             ex_err
   );

   modport slave (
      input  id_instr, id_valid, br_taken,
      output stall_if, flush_id, ex_valid, ex_alu_op, ex_alu_imm_src,
             ex_rf_write_en, ex_datamem_write_en, ex_datamem_read_en,
             ex_rf_write_mem_src, ex_pc_src, ex_pc_jmp_src, ex_rd, ex_uop,
             ex_err
   );
endinterface

// File: rtl/cpu_pipe_control.sv
// ---------------------------------------------------------------------------
// cpu_pipe_control
// Decodes the ID-stage instruction into the registered ID/EX control word and
// handles RAW/load-use stalls, taken-branch/jump flush, invalid opcodes and
// the two micro-op PUSH/POP sequence.
//
// Build option: CPU_CTRL_FWD_EN
//   defined   - datapath forwards EX/MEM results; only a load in EX whose rd
//               is read by ID stalls (one bubble).
//   undefined - no forwarding; any rf-writing instruction in EX or MEM whose
//               rd is read by ID stalls (up to two bubbles). Only this build
//               keeps the MEM-stage shadow, since nothing else reads it.
// ---------------------------------------------------------------------------
module cpu_pipe_control #(
   parameter int INSTR_W = 32,
   parameter int REG_AW  = 4,
   parameter int SP_IDX  = 15
) (
   input logic               clk,
   input logic               rst_n,
   cpu_pipe_control_if.slave bus
);

   localparam logic [REG_AW-1:0] SP_RD = REG_AW'(SP_IDX);

   typedef enum logic [0:0] {
      UOP0 = 1'b0,
      UOP1 = 1'b1
   } uop_state_e;

   typedef struct packed {
      logic              valid;
      logic [7:0]        alu_op;
      logic              alu_imm_src;
      logic              rf_we;
      logic              dm_we;
      logic              dm_re;
      logic              mem_src;
      logic              pc_src;
      logic              jmp_src;
      logic [REG_AW-1:0] rd;
      logic              uop;
      logic              err;
   } ctrl_t;

   // True when dst is one of the registers the ID instruction reads.
   function automatic logic src_match(
      input logic [REG_AW-1:0] dst,
      input logic [REG_AW-1:0] rs1,
      input logic [REG_AW-1:0] rs2,
      input logic [REG_AW-1:0] rd,
      input logic              use_rs1,
      input logic              use_rs2,
      input logic              use_rd,
      input logic              use_sp
   );
      src_match = (use_rs1 && (rs1 == dst)) ||
                  (use_rs2 && (rs2 == dst)) ||
                  (use_rd  && (rd  == dst)) ||
                  (use_sp  && (SP_RD == dst));
   endfunction

   uop_state_e        state_r;
   uop_state_e        state_nx_s;
   ctrl_t             ex_r;
   ctrl_t             ex_nx_s;
   ctrl_t             dec_s;

   logic [7:0]        op_s;
   logic [REG_AW-1:0] rd_s;
   logic [REG_AW-1:0] rs1_s;
   logic [REG_AW-1:0] rs2_s;
   logic              is_alu_s;
   logic              is_br_s;
   logic              is_load_s;
   logic              is_store_s;
   logic              is_push_s;
   logic              is_pop_s;
   logic              in_uop1_s;
   logic              use_rs1_s;
   logic              use_rs2_s;
   logic              use_rd_s;
   logic              use_sp_s;
   logic              hit_ex_s;
   logic              hit_mem_s;
   logic              hazard_s;
   logic              flush_s;
   logic              stall_s;
   logic              unused_instr_s;

   assign op_s  = bus.id_instr[INSTR_W-1 -: 8];
   assign rd_s  = bus.id_instr[INSTR_W-9 -: REG_AW];
   assign rs1_s = bus.id_instr[INSTR_W-9-REG_AW -: REG_AW];
   assign rs2_s = bus.id_instr[INSTR_W-9-2*REG_AW -: REG_AW];
   assign unused_instr_s = ^bus.id_instr[INSTR_W-9-3*REG_AW:0];

   assign is_alu_s   = (op_s[7:4] <= 4'h2);
   assign is_br_s    = (op_s[7:4] == 4'h3);
   assign is_load_s  = (op_s == 8'h81) || (op_s == 8'h85);
   assign is_store_s = (op_s == 8'h83) || (op_s == 8'h87);
   assign is_push_s  = (op_s == 8'h89);
   assign is_pop_s   = (op_s == 8'h8B);
   assign in_uop1_s  = (state_r == UOP1);

   // Decode ID into the control word and the set of registers it reads.
   always_comb begin
      dec_s        = '0;
      dec_s.valid  = 1'b1;
      dec_s.alu_op = op_s;
      dec_s.rd     = rd_s;
      use_rs1_s    = 1'b1;
      use_rs2_s    = 1'b0;
      use_rd_s     = 1'b0;
      use_sp_s     = 1'b0;
      if (is_alu_s) begin
         dec_s.alu_imm_src = op_s[0];
         dec_s.rf_we       = 1'b1;
         use_rs2_s         = ~op_s[0];
      end else if (is_br_s) begin
         dec_s.alu_imm_src = op_s[0];
         dec_s.pc_src      = 1'b1;
         dec_s.jmp_src     = (op_s == 8'h3F);
      end else if (is_load_s) begin
         dec_s.alu_imm_src = op_s[0];
         dec_s.rf_we       = 1'b1;
         dec_s.dm_re       = 1'b1;
         dec_s.mem_src     = 1'b1;
      end else if (is_store_s) begin
         dec_s.alu_imm_src = op_s[0];
         dec_s.dm_we       = 1'b1;
         use_rd_s          = 1'b1;
      end else if (is_push_s) begin
         // uop0: SP-1 -> SP, uop1: store rd to mem[SP]
         dec_s.alu_imm_src = op_s[0];
         dec_s.uop         = in_uop1_s;
         use_rd_s          = 1'b1;
         use_sp_s          = 1'b1;
         if (in_uop1_s) begin
            dec_s.dm_we = 1'b1;
         end else begin
            dec_s.rf_we = 1'b1;
            dec_s.rd    = SP_RD;
         end
      end else if (is_pop_s) begin
         // uop0: load mem[SP] -> rd, uop1: SP+1 -> SP
         dec_s.alu_imm_src = op_s[0];
         dec_s.uop         = in_uop1_s;
         use_sp_s          = 1'b1;
         dec_s.rf_we       = 1'b1;
         if (in_uop1_s) begin
            dec_s.rd = SP_RD;
         end else begin
            dec_s.dm_re   = 1'b1;
            dec_s.mem_src = 1'b1;
         end
      end else begin
         // unknown opcode travels as a flagged NOP
         dec_s.err = 1'b1;
         use_rs1_s = 1'b0;
      end
   end

`ifndef CPU_CTRL_FWD_EN
   logic              mem_valid_r;
   logic              mem_rf_we_r;
   logic [REG_AW-1:0] mem_rd_r;

   // MEM-stage shadow of the destination, needed while results are not forwarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_valid_r <= 1'b0;
         mem_rf_we_r <= 1'b0;
         mem_rd_r    <= '0;
      end else begin
         mem_valid_r <= ex_r.valid;
         mem_rf_we_r <= ex_r.rf_we;
         mem_rd_r    <= ex_r.rd;
      end
   end
`endif

   // Compare ID sources against in-flight destinations not yet readable.
   always_comb begin
      hit_ex_s  = 1'b0;
      hit_mem_s = 1'b0;
`ifdef CPU_CTRL_FWD_EN
      if (ex_r.valid && ex_r.dm_re) begin
         hit_ex_s = src_match(ex_r.rd, rs1_s, rs2_s, rd_s,
                              use_rs1_s, use_rs2_s, use_rd_s, use_sp_s);
      end else begin
         hit_ex_s = 1'b0;
      end
`else
      if (ex_r.valid && ex_r.rf_we) begin
         hit_ex_s = src_match(ex_r.rd, rs1_s, rs2_s, rd_s,
                              use_rs1_s, use_rs2_s, use_rd_s, use_sp_s);
      end else begin
         hit_ex_s = 1'b0;
      end
      if (mem_valid_r && mem_rf_we_r) begin
         hit_mem_s = src_match(mem_rd_r, rs1_s, rs2_s, rd_s,
                               use_rs1_s, use_rs2_s, use_rd_s, use_sp_s);
      end else begin
         hit_mem_s = 1'b0;
      end
`endif
   end

   assign hazard_s = bus.id_valid & (hit_ex_s | hit_mem_s);

   // JMP (0x3E) and JMPI (0x3F) redirect regardless of the branch condition.
   assign flush_s = ex_r.valid & ex_r.pc_src &
                    (bus.br_taken | (ex_r.alu_op[3:0] == 4'hF) |
                     (ex_r.alu_op[3:0] == 4'hE));

   // Select what enters ID/EX, whether IF holds, and the micro-op state.
   always_comb begin
      ex_nx_s    = '0;
      state_nx_s = state_r;
      stall_s    = 1'b0;
      if (flush_s) begin
         // flush wins over stall and abandons any pending second micro-op
         state_nx_s = UOP0;
      end else if (!bus.id_valid) begin
         state_nx_s = state_r;
      end else if (hazard_s) begin
         stall_s = 1'b1;
      end else begin
         ex_nx_s = dec_s;
         case (state_r)
            UOP0: begin
               if (is_push_s || is_pop_s) begin
                  stall_s    = 1'b1;
                  state_nx_s = UOP1;
               end else begin
                  state_nx_s = UOP0;
               end
            end
            UOP1:    state_nx_s = UOP0;
            default: state_nx_s = UOP0;
         endcase
      end
   end

   // Micro-op state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= UOP0;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // ID/EX control register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_r <= '0;
      end else begin
         ex_r <= ex_nx_s;
      end
   end

   assign bus.stall_if            = stall_s;
   assign bus.flush_id            = flush_s;
   assign bus.ex_valid            = ex_r.valid;
   assign bus.ex_alu_op           = ex_r.alu_op;
   assign bus.ex_alu_imm_src      = ex_r.alu_imm_src;
   assign bus.ex_rf_write_en      = ex_r.rf_we;
   assign bus.ex_datamem_write_en = ex_r.dm_we;
   assign bus.ex_datamem_read_en  = ex_r.dm_re;
   assign bus.ex_rf_write_mem_src = ex_r.mem_src;
   assign bus.ex_pc_src           = ex_r.pc_src;
   assign bus.ex_pc_jmp_src       = ex_r.jmp_src;
   assign bus.ex_rd               = ex_r.rd;
   assign bus.ex_uop              = ex_r.uop;
   assign bus.ex_err              = ex_r.err;

endmodule

// File: tb/tb_cpu_pipe_control.sv
// ---------------------------------------------------------------------------
// tb_cpu_pipe_control
// Directed bench for cpu_pipe_control: reset, load-use/RAW stalls, branch
// flush, PUSH/POP sequencing and invalid opcodes. Expected bubble counts
// follow the CPU_CTRL_FWD_EN build option.
// ---------------------------------------------------------------------------
module tb_cpu_pipe_control;

   localparam int INSTR_W = 32;
   localparam int REG_AW  = 4;
   localparam int SP_IDX  = 15;
`ifdef CPU_CTRL_FWD_EN
   localparam int FWD = 1;
`else
   localparam int FWD = 0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   cpu_pipe_control_if #(.INSTR_W(INSTR_W), .REG_AW(REG_AW)) bus ();

   cpu_pipe_control #(
      .INSTR_W(INSTR_W),
      .REG_AW (REG_AW),
      .SP_IDX (SP_IDX)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [7:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2);
      return {op, rd, rs1, rs2, 12'h000};
   endfunction

   // {valid, uop, err, rd, alu_op, imm, rf_we, dm_we, dm_re, mem_src, pc_src, jmp}
   function automatic logic [21:0] ex_obs();
      return {bus.ex_valid, bus.ex_uop, bus.ex_err, bus.ex_rd, bus.ex_alu_op,
              bus.ex_alu_imm_src, bus.ex_rf_write_en, bus.ex_datamem_write_en,
              bus.ex_datamem_read_en, bus.ex_rf_write_mem_src, bus.ex_pc_src,
              bus.ex_pc_jmp_src};
   endfunction

   function automatic logic [21:0] exp_st(input logic v, input logic u, input logic e,
                                          input logic [3:0] rd, input logic [7:0] op,
                                          input logic [6:0] en);
      return {v, u, e, rd, op, en};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] instr, input logic v, input logic br);
      bus.id_instr = instr;
      bus.id_valid = v;
      bus.br_taken = br;
      #1;
   endtask

   task automatic idle(input int n);
      drive(32'h0, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      logic [21:0] want;
      rst_n = 1'b0;
      drive(32'h0, 1'b0, 1'b0);
      tick(); tick(); tick();
      checks++;
      if (ex_obs() !== 22'h0 || {bus.stall_if, bus.flush_id} !== 2'b00) begin
         errors++;
         $display("FAIL reset_state: got ex=%h sf=%b want ex=0 sf=00", ex_obs(), {bus.stall_if, bus.flush_id});
      end
      rst_n = 1'b1;
      drive(mk(8'h00, 4'd1, 4'd2, 4'd3), 1'b1, 1'b0);
      tick();
      want = exp_st(1'b1, 1'b0, 1'b0, 4'd1, 8'h00, 7'b0100000);
      checks++;
      if (ex_obs() !== want) begin
         errors++; $display("FAIL reset_add: got %h want %h", ex_obs(), want);
      end
      // abandon PUSH after uop0 with a reset
      drive(mk(8'h89, 4'd5, 4'd0, 4'd0), 1'b1, 1'b0);
      tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if (ex_obs() !== 22'h0) begin
         errors++; $display("FAIL reset_mid_push: got %h want 0", ex_obs());
      end
      tick(); tick();
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus.stall_if !== 1'b1) begin
         errors++; $display("FAIL reset_fsm_uop0_stall: got %b want 1", bus.stall_if);
      end
      tick();
      want = exp_st(1'b1, 1'b0, 1'b0, 4'd15, 8'h89, 7'b1100000);
      checks++;
      if (ex_obs() !== want) begin
         errors++; $display("FAIL reset_push_restart: got %h want %h", ex_obs(), want);
      end
      for (int i = 0; i < 6 && bus.stall_if === 1'b1; i++) tick();
      tick();
      idle(3);
   endtask

   task automatic test_load_use();
      logic [21:0] want;
      int n;
      idle(3);
      drive(mk(8'h85, 4'd3, 4'd1, 4'd0), 1'b1, 1'b0);
      tick();
      want = exp_st(1'b1, 1'b0, 1'b0, 4'd3, 8'h85, 7'b1101100);
      checks++;
      if (ex_obs() !== want) begin
         errors++; $display("FAIL ld_decode: got %h want %h", ex_obs(), want);
      end
      drive(mk(8'h00, 4'd4, 4'd3, 4'd2), 1'b1, 1'b0);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.stall_if === 1'b1) begin
            n++;
            tick();
            checks++;
            if (ex_obs() !== 22'h0) begin
               errors++; $display("FAIL ld_use_bubble: got %h want 0", ex_obs());
            end
         end
      end
      checks++;
      if (n !== ((FWD != 0) ? 1 : 2)) begin
         errors++; $display("FAIL ld_use_stalls: got %0d want %0d", n, (FWD != 0) ? 1 : 2);
      end
      tick();
      want = exp_st(1'b1, 1'b0, 1'b0, 4'd4, 8'h00, 7'b0100000);
      checks++;
      if (ex_obs() !== want) begin
         errors++; $display("FAIL ld_use_issue: got %h want %h", ex_obs(), want);
      end
      // ALU-to-ALU dependency through rs1
      idle(3);
      drive(mk(8'h00, 4'd6, 4'd1, 4'd2), 1'b1, 1'b0);
      tick();
      drive(mk(8'h02, 4'd7, 4'd6, 4'd1), 1'b1, 1'b0);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.stall_if === 1'b1) begin
            n++;
            tick();
         end
      end
      checks++;
      if (n !== ((FWD != 0) ? 0 : 2)) begin
         errors++; $display("FAIL alu_raw_stalls: got %0d want %0d", n, (FWD != 0) ? 0 : 2);
      end
      tick();
      want = exp_st(1'b1, 1'b0, 1'b0, 4'd7, 8'h02, 7'b0100000);
      checks++;
      if (ex_obs() !== want) begin
         errors++; $display("FAIL alu_raw_issue: got %h want %h", ex_obs(), want);
      end
      // immediate form ignores the rs2 field
      idle(3);
      drive(mk(8'h00, 4'd6, 4'd1, 4'd2), 1'b1, 1'b0);
      tick();
      drive(mk(8'h01, 4'd8, 4'd1, 4'd6), 1'b1, 1'b0);
      checks++;
      if (bus.stall_if !== 1'b0) begin
         errors++; $display("FAIL imm_no_rs2: got stall %b want 0", bus.stall_if);
      end
      tick();
      want = exp_st(1'b1, 1'b0, 1'b0, 4'd8, 8'h01, 7'b1100000);
      checks++;
      if (ex_obs() !== want) begin
         errors++; $display("FAIL imm_issue: got %h want %h", ex_obs(), want);
      end
      // store data register depends on a load
      idle(3);
      drive(mk(8'h85, 4'd5, 4'd1, 4'd0), 1'b1, 1'b0);
      tick();
      drive(mk(8'h87, 4'd5, 4'd1, 4'd0), 1'b1, 1'b0);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.stall_if === 1'b1) begin
            n++;
            tick();
         end
      end
      checks++;
      if (n !== ((FWD != 0) ? 1 : 2)) begin
         errors++; $display("FAIL st_rd_stalls: got %0d want %0d", n, (FWD != 0) ? 1 : 2);
      end
      tick();
      want = exp_st(1'b1, 1'b0, 1'b0, 4'd5, 8'h87, 7'b1010000);
      checks++;
      if (ex_obs() !== want) begin
         errors++; $display("FAIL st_issue: got %h want %h", ex_obs(), want);
      end
      idle(3);
   endtask

   task automatic test_branch();
      logic [21:0] want;
      idle(3);
      drive(mk(8'h3F, 4'd0, 4'd2, 4'd0), 1'b1, 1'b0);
      tick();
      want = exp_st(1'b1, 1'b0, 1'b0, 4'd0, 8'h3F, 7'b1000011);
      checks++;
      if (ex_obs() !== want) begin
         errors++; $display("FAIL jmpi_decode: got %h want %h", ex_obs(), want);
      end
      drive(mk(8'h00, 4'd9, 4'd1, 4'd2), 1'b1, 1'b0);
      checks++;
      if ({bus.stall_if, bus.flush_id} !== 2'b01) begin
         errors++; $display("FAIL jmpi_flush: got sf=%b want 01", {bus.stall_if, bus.flush_id});
      end
      tick();
      checks++;
      if (ex_obs() !== 22'h0) begin
         errors++; $display("FAIL jmpi_bubble: got %h want 0", ex_obs());
      end
      drive(mk(8'h30, 4'd0, 4'd1, 4'd2), 1'b1, 1'b0);
      tick();
      want = exp_st(1'b1, 1'b0, 1'b0, 4'd0, 8'h30, 7'b0000010);
      checks++;
      if (ex_obs() !== want) begin
         errors++; $display("FAIL br_decode: got %h want %h", ex_obs(), want);
      end
      drive(mk(8'h00, 4'd9, 4'd1, 4'd2), 1'b1, 1'b0);
      checks++;
      if (bus.flush_id !== 1'b0) begin
         errors++; $display("FAIL br_not_taken_flush: got %b want 0", bus.flush_id);
      end
      tick();
      drive(mk(8'h30, 4'd0, 4'd1, 4'd2), 1'b1, 1'b0);
      tick();
      drive(mk(8'h00, 4'd9, 4'd1, 4'd2), 1'b1, 1'b1);
      checks++;
      if (bus.flush_id !== 1'b1) begin
         errors++; $display("FAIL br_taken_flush: got %b want 1", bus.flush_id);
      end
      tick();
      checks++;
      if (ex_obs() !== 22'h0) begin
         errors++; $display("FAIL br_taken_bubble: got %h want 0", ex_obs());
      end
      // flush with a dependent instruction in ID: flush wins, no stall
      idle(3);
      drive(mk(8'h00, 4'd1, 4'd2, 4'd3), 1'b1, 1'b0);
      tick();
      drive(mk(8'h3F, 4'd0, 4'd2, 4'd0), 1'b1, 1'b0);
      tick();
      drive(mk(8'h00, 4'd10, 4'd1, 4'd2), 1'b1, 1'b0);
      checks++;
      if ({bus.stall_if, bus.flush_id} !== 2'b01) begin
         errors++; $display("FAIL flush_over_stall: got sf=%b want 01", {bus.stall_if, bus.flush_id});
      end
      tick();
      idle(3);
   endtask

   task automatic test_push_pop();
      logic [21:0] want;
      int n;
      idle(3);
      drive(mk(8'h89, 4'd5, 4'd0, 4'd0), 1'b1, 1'b0);
      n = (bus.stall_if === 1'b1) ? 1 : 0;
      tick();
      want = exp_st(1'b1, 1'b0, 1'b0, 4'd15, 8'h89, 7'b1100000);
      checks++;
      if (ex_obs() !== want) begin
         errors++; $display("FAIL push_uop0: got %h want %h", ex_obs(), want);
      end
      for (int i = 0; i < 6; i++) begin
         if (bus.stall_if === 1'b1) begin
            n++;
            tick();
         end
      end
      checks++;
      if (n !== ((FWD != 0) ? 1 : 3)) begin
         errors++; $display("FAIL push_stall_cycles: got %0d want %0d", n, (FWD != 0) ? 1 : 3);
      end
      tick();
      want = exp_st(1'b1, 1'b1, 1'b0, 4'd5, 8'h89, 7'b1010000);
      checks++;
      if (ex_obs() !== want) begin
         errors++; $display("FAIL push_uop1: got %h want %h", ex_obs(), want);
      end
      idle(3);
      drive(mk(8'h8B, 4'd6, 4'd0, 4'd0), 1'b1, 1'b0);
      tick();
      want = exp_st(1'b1, 1'b0, 1'b0, 4'd6, 8'h8B, 7'b1101100);
      checks++;
      if (ex_obs() !== want || bus.stall_if !== 1'b0) begin
         errors++; $display("FAIL pop_uop0: got %h stall %b want %h stall 0", ex_obs(), bus.stall_if, want);
      end
      tick();
      want = exp_st(1'b1, 1'b1, 1'b0, 4'd15, 8'h8B, 7'b1100000);
      checks++;
      if (ex_obs() !== want) begin
         errors++; $display("FAIL pop_uop1: got %h want %h", ex_obs(), want);
      end
      // jump in EX squashes a PUSH waiting in ID before any micro-op issues
      idle(3);
      drive(mk(8'h3E, 4'd0, 4'd2, 4'd0), 1'b1, 1'b0);
      tick();
      want = exp_st(1'b1, 1'b0, 1'b0, 4'd0, 8'h3E, 7'b0000010);
      checks++;
      if (ex_obs() !== want) begin
         errors++; $display("FAIL jmp_decode: got %h want %h", ex_obs(), want);
      end
      drive(mk(8'h89, 4'd5, 4'd0, 4'd0), 1'b1, 1'b0);
      checks++;
      if ({bus.stall_if, bus.flush_id} !== 2'b01) begin
         errors++; $display("FAIL push_flushed: got sf=%b want 01", {bus.stall_if, bus.flush_id});
      end
      tick();
      checks++;
      if (ex_obs() !== 22'h0 || {bus.stall_if, bus.flush_id} !== 2'b10) begin
         errors++; $display("FAIL push_after_flush: got ex=%h sf=%b want ex=0 sf=10", ex_obs(), {bus.stall_if, bus.flush_id});
      end
      tick();
      for (int i = 0; i < 6 && bus.stall_if === 1'b1; i++) tick();
      tick();
      want = exp_st(1'b1, 1'b1, 1'b0, 4'd5, 8'h89, 7'b1010000);
      checks++;
      if (ex_obs() !== want) begin
         errors++; $display("FAIL push_replay_uop1: got %h want %h", ex_obs(), want);
      end
      idle(3);
   endtask

   task automatic test_invalid();
      logic [21:0] want;
      idle(3);
      drive(mk(8'h9A, 4'd3, 4'd1, 4'd2), 1'b1, 1'b0);
      tick();
      want = exp_st(1'b1, 1'b0, 1'b1, 4'd3, 8'h9A, 7'b0000000);
      checks++;
      if (ex_obs() !== want) begin
         errors++; $display("FAIL invalid_op: got %h want %h", ex_obs(), want);
      end
      drive(mk(8'h00, 4'd4, 4'd3, 4'd2), 1'b1, 1'b0);
      checks++;
      if ({bus.stall_if, bus.flush_id} !== 2'b00) begin
         errors++; $display("FAIL invalid_no_hazard: got sf=%b want 00", {bus.stall_if, bus.flush_id});
      end
      tick();
      drive(mk(8'h83, 4'd5, 4'd1, 4'd2), 1'b1, 1'b0);
      tick();
      want = exp_st(1'b1, 1'b0, 1'b0, 4'd5, 8'h83, 7'b1010000);
      checks++;
      if (ex_obs() !== want) begin
         errors++; $display("FAIL store_decode: got %h want %h", ex_obs(), want);
      end
      idle(3);
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.id_instr = 32'h0;
      bus.id_valid = 1'b0;
      bus.br_taken = 1'b0;
      test_reset();
      test_load_use();
      test_branch();
      test_push_pop();
      test_invalid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
